ntt_stage_ctrl: RTL and testbench
=================================

Name: ntt_stage_ctrl

Overview:
- Sequencer for one butterfly pipeline and its coefficient memory. Runs all LOGN stages of an in-place radix-2 N-point NTT, N = 2^LOGN.
- Each cycle during issue it produces one read address pair, the twiddle index, and a valid strobe for the butterfly.
- It delays the address pair by the butterfly latency so results are written back to the same locations.
- Inserts a drain gap between stages so no stage reads data still in flight.

Parameters:
- LOGN, 10, log2 of transform size N; legal range 2..16.
- LAT, 8, butterfly pipeline latency in cycles from issue to result; legal range 1..31.
- AW, LOGN, coefficient memory address width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a transform; sampled only in IDLE.
- abort  input  1  synchronous cancel; return to IDLE and kill in-flight writes.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when the last write-back has been issued.
- rd_valid  output  1  butterfly operands issued this cycle.
- rd_addr_x  output  AW  address of the x operand.
- rd_addr_y  output  AW  address of the y operand.
- tw_idx  output  LOGN-1  twiddle table index for this butterfly.
- stage  output  $clog2(LOGN)  current stage number.
- wr_valid  output  1  butterfly result available; write x_out/y_out this cycle.
- wr_addr_x  output  AW  address for the x_out write.
- wr_addr_y  output  AW  address for the y_out write.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; delay line cleared.
- Outputs are registered.
- State machine:
  - IDLE: wait for start=1, then go to ISSUE with stage=0 and j=0.
  - ISSUE: rd_valid=1 for exactly N/2 consecutive cycles; j counts 0..N/2-1. After j=N/2-1 go to DRAIN.
  - DRAIN: rd_valid=0 for exactly LAT cycles. Then, if stage<LOGN-1, increment stage, clear j and go to ISSUE. Otherwise go to DONE.
  - DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Addressing for stage s, butterfly j:
  - g = j>>s, p = j & (2^s-1).
  - rd_addr_x = (g<<(s+1)) | p.
  - rd_addr_y = rd_addr_x + 2^s.
  - tw_idx = p<<(LOGN-1-s).
  - All values are unsigned; no wrap is possible inside legal ranges.
- Write-back delay line:
  - LAT-deep shift register of {valid, addr_x, addr_y}.
  - wr_* at cycle t+LAT equal rd_* at cycle t, bit-exact.
  - The last write of a stage therefore lands in that stage's final drain cycle, before the next stage's first read.
- Timing: start seen at edge 0 → first rd_valid at cycle 1. done at cycle LOGN*(N/2+LAT)+1.
- start during a busy transform (states other than IDLE) is ignored; no queuing.
- abort=1 in any state:
  - Next cycle: state=IDLE, busy=0, rd_valid=0, delay line cleared (wr_valid=0), done not pulsed.
  - abort has priority over start in the same cycle.
- rst asserted mid-transform behaves like abort but takes effect asynchronously.

Optional Feature:
- Macro: NTT_STAGE_CTRL_INVERSE_EN.
- Defined:
  - Adds input port inverse (1 bit), sampled together with start.
  - When inverse=1, stages run in Gentleman-Sande order s = LOGN-1 down to 0, using the same address and twiddle formulas per s.
  - Output tw_inv (1 bit) is held high for the whole transform to select the inverse twiddle table.
  - The stage output reports the actual s.
- Not defined: no inverse or tw_inv ports; forward order only.

Test Plan (LOGN=3, LAT=2 unless stated):
- Reset then start pulse at cycle 0 → rd_valid at cycles 1-4 with stage 0 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0; cycles 5-6 idle.
- Same run → stage 1 at cycles 7-10: (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2. Stage 2 at cycles 13-16: (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3.
- Same run → wr_valid at cycles 3-6, 9-12 and 15-18, with addresses equal to the reads 2 cycles earlier. done=1 only at cycle 19; busy=1 over cycles 1-19.
- abort=1 at cycle 9 → cycle 10 shows busy=0, rd_valid=0, wr_valid=0, no done pulse. A new start then reproduces the full sequence from stage 0.
- start pulses at cycles 5 and 12 during a run → ignored; done still at cycle 19 only. Asynchronous rst pulse mid-stage → all outputs 0 immediately.
- NTT_STAGE_CTRL_INVERSE_EN defined, inverse=1 → first issued stage is 2 with pairs (0,4),(1,5),(2,6),(3,7); tw_inv=1 throughout; done at cycle 19.

Source files
------------

// File: rtl/ntt_stage_ctrl.sv
// -----------------------------------------------------------------------------
// ntt_stage_ctrl
//
// Sequencer for a single radix-2 butterfly pipeline running an in-place
// N-point NTT (N = 2**LOGN). For every stage it issues N/2 butterflies, one
// per cycle, then idles for LAT cycles so the last result of the stage is
// written back before the next stage reads it. The read address pair is
// delayed LAT cycles to form the write-back address pair.
//
// Optional feature macro: NTT_STAGE_CTRL_INVERSE_EN
//   When defined, adds input inverse_i (sampled with start_i) and output
//   tw_inv_o. An inverse transform runs stages LOGN-1 down to 0 and holds
//   tw_inv_o high for the whole transform.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      request a transform (sampled only in IDLE)
//   abort_i      synchronous cancel, kills in-flight write-backs
//   busy_o       transform in progress
//   done_o       one-cycle pulse after the last write-back is issued
//   rd_valid_o   butterfly operands issued this cycle
//   rd_addr_x_o  x operand address
//   rd_addr_y_o  y operand address
//   tw_idx_o     twiddle table index
//   stage_o      current stage number
//   wr_valid_o   butterfly result to be written this cycle
//   wr_addr_x_o  x result address
//   wr_addr_y_o  y result address
//   inverse_i    (macro only) run inverse stage order
//   tw_inv_o     (macro only) select inverse twiddle table
// -----------------------------------------------------------------------------
module ntt_stage_ctrl #(
    parameter int LOGN = 10,
    parameter int LAT  = 8,
    parameter int AW   = LOGN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_valid_o,
    output logic [AW-1:0]            rd_addr_x_o,
    output logic [AW-1:0]            rd_addr_y_o,
    output logic [LOGN-2:0]          tw_idx_o,
    output logic [$clog2(LOGN)-1:0]  stage_o,
    output logic                     wr_valid_o,
    output logic [AW-1:0]            wr_addr_x_o,
    output logic [AW-1:0]            wr_addr_y_o
`ifdef NTT_STAGE_CTRL_INVERSE_EN
    ,
    input  logic                     inverse_i,
    output logic                     tw_inv_o
`endif
);

    localparam int JW = LOGN - 1;          // butterfly index width (N/2 per stage)
    localparam int SW = $clog2(LOGN);      // stage number width
    localparam int DW = 5;                 // drain counter, LAT <= 31
    localparam int PW = 2 * AW + 1;        // delay line word {valid, x, y}

    localparam logic [JW-1:0] J_LAST     = {JW{1'b1}};
    localparam logic [SW-1:0] STAGE_TOP  = SW'(LOGN - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            inv_q, inv_d;
    logic            inv_req;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_valid_q, rd_valid_d;
    logic [AW-1:0]   rd_x_q, rd_x_d;
    logic [AW-1:0]   rd_y_q, rd_y_d;
    logic [JW-1:0]   tw_q, tw_d;
    logic [SW-1:0]   stage_out_q, stage_out_d;
`ifdef NTT_STAGE_CTRL_INVERSE_EN
    logic            tw_inv_q, tw_inv_d;
`endif

    logic [PW-1:0]   pipe_q [LAT];

    logic [AW-1:0]   j_ext;
    logic [AW-1:0]   mask;
    logic [AW-1:0]   p_val;
    logic [AW-1:0]   g_val;
    logic [AW-1:0]   addr_x;
    logic [AW-1:0]   addr_y;
    logic [JW-1:0]   tw_val;
    logic            stage_last;

`ifdef NTT_STAGE_CTRL_INVERSE_EN
    assign inv_req = inverse_i;
`else
    assign inv_req = 1'b0;
`endif

    // Butterfly addressing: x is j with a zero bit inserted at position s,
    // y is the same with that bit set; twiddle is the low part of j scaled up.
    always_comb begin
        j_ext  = AW'(j_q);
        mask   = (AW'(1) << stage_q) - AW'(1);
        p_val  = j_ext & mask;
        g_val  = j_ext >> stage_q;
        addr_x = ((g_val << stage_q) << 1) | p_val;
        addr_y = addr_x + (AW'(1) << stage_q);
        tw_val = JW'(p_val) << (STAGE_TOP - stage_q);
    end

    // Final stage depends on the running direction.
    always_comb begin
        if (inv_q) begin
            stage_last = (stage_q == SW'(0));
        end else begin
            stage_last = (stage_q == STAGE_TOP);
        end
    end

    // Next-state and next-output logic; outputs lag the state by one cycle.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        j_d         = j_q;
        drain_d     = drain_q;
        inv_d       = inv_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rd_valid_d  = 1'b0;
        rd_x_d      = AW'(0);
        rd_y_d      = AW'(0);
        tw_d        = JW'(0);
        stage_out_d = SW'(0);
`ifdef NTT_STAGE_CTRL_INVERSE_EN
        tw_inv_d    = 1'b0;
`endif
        if (abort_i) begin
            state_d = ST_IDLE;
            stage_d = SW'(0);
            j_d     = JW'(0);
            drain_d = DW'(0);
            inv_d   = 1'b0;
        end else begin
            busy_d = (state_q != ST_IDLE);
            if (state_q != ST_IDLE) begin
                stage_out_d = stage_q;
            end else begin
                stage_out_d = SW'(0);
            end
`ifdef NTT_STAGE_CTRL_INVERSE_EN
            tw_inv_d = inv_q & (state_q != ST_IDLE);
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_ISSUE;
                        j_d     = JW'(0);
                        drain_d = DW'(0);
                        inv_d   = inv_req;
                        if (inv_req) begin
                            stage_d = STAGE_TOP;
                        end else begin
                            stage_d = SW'(0);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    rd_valid_d = 1'b1;
                    rd_x_d     = addr_x;
                    rd_y_d     = addr_y;
                    tw_d       = tw_val;
                    j_d        = j_q + JW'(1);
                    if (j_q == J_LAST) begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(0);
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    drain_d = drain_q + DW'(1);
                    if (drain_q == DRAIN_LAST) begin
                        drain_d = DW'(0);
                        j_d     = JW'(0);
                        if (stage_last) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ISSUE;
                            if (inv_q) begin
                                stage_d = stage_q - SW'(1);
                            end else begin
                                stage_d = stage_q + SW'(1);
                            end
                        end
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    stage_d = SW'(0);
                    inv_d   = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            stage_q <= SW'(0);
            j_q     <= JW'(0);
            drain_q <= DW'(0);
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            drain_q <= drain_d;
            inv_q   <= inv_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_x_q      <= AW'(0);
            rd_y_q      <= AW'(0);
            tw_q        <= JW'(0);
            stage_out_q <= SW'(0);
`ifdef NTT_STAGE_CTRL_INVERSE_EN
            tw_inv_q    <= 1'b0;
`endif
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            tw_q        <= tw_d;
            stage_out_q <= stage_out_d;
`ifdef NTT_STAGE_CTRL_INVERSE_EN
            tw_inv_q    <= tw_inv_d;
`endif
        end
    end

    // Write-back delay line: the tail reproduces the issued reads LAT cycles later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= PW'(0);
            end
        end else if (abort_i) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= PW'(0);
            end
        end else begin
            pipe_q[0] <= {rd_valid_q, rd_x_q, rd_y_q};
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_addr_x_o = rd_x_q;
    assign rd_addr_y_o = rd_y_q;
    assign tw_idx_o    = tw_q;
    assign stage_o     = stage_out_q;
    assign wr_valid_o  = pipe_q[LAT-1][PW-1];
    assign wr_addr_x_o = pipe_q[LAT-1][2*AW-1:AW];
    assign wr_addr_y_o = pipe_q[LAT-1][AW-1:0];
`ifdef NTT_STAGE_CTRL_INVERSE_EN
    assign tw_inv_o    = tw_inv_q;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl with LOGN=3 (N=8), LAT=2.
module tb_ntt_stage_ctrl;

    localparam int LOGN = 3;
    localparam int LAT  = 2;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            rd_valid;
    logic [AW-1:0]   rd_addr_x;
    logic [AW-1:0]   rd_addr_y;
    logic [LOGN-2:0] tw_idx;
    logic [1:0]      stage;
    logic            wr_valid;
    logic [AW-1:0]   wr_addr_x;
    logic [AW-1:0]   wr_addr_y;
`ifdef NTT_STAGE_CTRL_INVERSE_EN
    logic            inverse;
    logic            tw_inv;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-derived butterfly table, indexed by stage*4 + j.
    int tx  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int ty  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int ttw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    ntt_stage_ctrl #(.LOGN(LOGN), .LAT(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .rd_valid_o  (rd_valid),
        .rd_addr_x_o (rd_addr_x),
        .rd_addr_y_o (rd_addr_y),
        .tw_idx_o    (tw_idx),
        .stage_o     (stage),
        .wr_valid_o  (wr_valid),
        .wr_addr_x_o (wr_addr_x),
        .wr_addr_y_o (wr_addr_y)
`ifdef NTT_STAGE_CTRL_INVERSE_EN
        ,
        .inverse_i   (inverse),
        .tw_inv_o    (tw_inv)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int c);
        chk({tag, "_busy"},     c, 32'(busy),     32'd0);
        chk({tag, "_done"},     c, 32'(done),     32'd0);
        chk({tag, "_rd_valid"}, c, 32'(rd_valid), 32'd0);
        chk({tag, "_wr_valid"}, c, 32'(wr_valid), 32'd0);
    endtask

    // One full transform; start is sampled at edge 0, cycle c is the period after edge c.
    task automatic check_run(input bit inv, input bit stray);
        int  k;
        int  m;
        int  s;
        int  cw;
        bit  rdv;
        bit  wrv;
        start = 1'b1;
`ifdef NTT_STAGE_CTRL_INVERSE_EN
        inverse = inv;
`endif
        step();
        start = 1'b0;
`ifdef NTT_STAGE_CTRL_INVERSE_EN
        inverse = 1'b0;
`endif
        chk("busy_c0", 0, 32'(busy), 32'd0);
        for (int c = 1; c <= 21; c++) begin
            step();
            k   = (c - 1) / 6;
            m   = (c - 1) % 6;
            s   = inv ? (2 - k) : k;
            rdv = (c <= 18) && (m < 4);
            chk("rd_valid", c, 32'(rd_valid), 32'(rdv));
            if (rdv) begin
                chk("rd_addr_x", c, 32'(rd_addr_x), 32'(tx[s*4+m]));
                chk("rd_addr_y", c, 32'(rd_addr_y), 32'(ty[s*4+m]));
                chk("tw_idx",    c, 32'(tw_idx),    32'(ttw[s*4+m]));
                chk("stage",     c, 32'(stage),     32'(s));
            end
            cw  = c - 2;
            wrv = (cw >= 1) && (cw <= 18) && (((cw - 1) % 6) < 4);
            chk("wr_valid", c, 32'(wr_valid), 32'(wrv));
            if (wrv) begin
                k = (cw - 1) / 6;
                m = (cw - 1) % 6;
                s = inv ? (2 - k) : k;
                chk("wr_addr_x", c, 32'(wr_addr_x), 32'(tx[s*4+m]));
                chk("wr_addr_y", c, 32'(wr_addr_y), 32'(ty[s*4+m]));
            end
            chk("busy", c, 32'(busy), 32'(c <= 19));
            chk("done", c, 32'(done), 32'(c == 19));
`ifdef NTT_STAGE_CTRL_INVERSE_EN
            chk("tw_inv", c, 32'(tw_inv), 32'(inv && (c <= 19)));
`endif
            start = stray && (c == 5 || c == 12);
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
`ifdef NTT_STAGE_CTRL_INVERSE_EN
        inverse = 1'b0;
`endif
        #1;
        check_idle("reset", 0);
        chk("reset_rd_addr_x", 0, 32'(rd_addr_x), 32'd0);
        chk("reset_stage",     0, 32'(stage),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_idle("post_reset", 0);

        // Plain forward transform.
        check_run(1'b0, 1'b0);

        // Stray start pulses during the run are ignored.
        check_run(1'b0, 1'b1);

        // Abort in the middle of stage 1.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            step();
        end
        chk("pre_abort_busy", 9, 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort", 10);
        for (int c = 11; c <= 22; c++) begin
            step();
            chk("abort_no_done", c, 32'(done), 32'd0);
            chk("abort_no_wr",   c, 32'(wr_valid), 32'd0);
            chk("abort_no_busy", c, 32'(busy), 32'd0);
        end

        // A fresh start after the abort runs the full sequence again.
        check_run(1'b0, 1'b0);

        // abort beats start in the same cycle.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        chk("prio_busy", 1, 32'(busy), 32'd0);
        step();
        chk("prio_rd_valid", 2, 32'(rd_valid), 32'd0);

        // Asynchronous reset in the middle of stage 1.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
        end
        chk("pre_rst_rd_valid", 8, 32'(rd_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst", 8);
        chk("async_rst_rd_addr_x", 8, 32'(rd_addr_x), 32'd0);
        chk("async_rst_rd_addr_y", 8, 32'(rd_addr_y), 32'd0);
        chk("async_rst_stage",     8, 32'(stage),     32'd0);
        #2;
        rst = 1'b0;
        step();
        check_idle("after_rst", 9);

        // Full run after the reset.
        check_run(1'b0, 1'b0);

`ifdef NTT_STAGE_CTRL_INVERSE_EN
        check_run(1'b1, 1'b0);
        check_run(1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
